// File: rtl/layer_scheduler_if.sv
// Bundles the layer-control and Neuron-side signals of the layer scheduler.
// master = the scheduler itself, slave = the layer top / Neuron / bank mux side.
interface layer_scheduler_if #(
  parameter int N                 = 8,
  parameter int NUM_NEURONS       = 10,
  parameter int CLOG2_NUM_NEURONS = 4
);
  logic                         start;
  logic                         neuron_ready;
  logic [N-1:0]                 neuron_result;
  logic                         neuron_rst;
  logic                         neuron_en;
  logic [CLOG2_NUM_NEURONS-1:0] neuron_sel;
  logic [NUM_NEURONS*N-1:0]     results;
  logic                         busy;
  logic                         done;
  logic                         error;

  modport master (
    input  start, neuron_ready, neuron_result,
    output neuron_rst, neuron_en, neuron_sel, results, busy, done, error
  );

  modport slave (
    output start, neuron_ready, neuron_result,
    input  neuron_rst, neuron_en, neuron_sel, results, busy, done, error
  );
endinterface

// File: rtl/layer_scheduler.sv
// Time-multiplexes a single Neuron datapath across NUM_NEURONS outputs of one
// MLP layer: clear, run until ready (watchdog-bounded), capture, next index.
module layer_scheduler #(
  parameter int N                 = 8,
  parameter int NUM_NEURONS       = 10,
  parameter int CLOG2_NUM_NEURONS = 4,
  parameter int TIMEOUT           = 16,
  parameter int CLOG2_TIMEOUT     = 4
) (
  input logic              clk,
  input logic              rst,
  layer_scheduler_if.master bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  localparam logic [CLOG2_NUM_NEURONS-1:0] SEL_LAST  = CLOG2_NUM_NEURONS'(NUM_NEURONS - 1);
  localparam logic [CLOG2_TIMEOUT-1:0]     WDOG_LAST = CLOG2_TIMEOUT'(TIMEOUT - 1);

  logic [2:0]                   state_q,   state_d;
  logic [CLOG2_NUM_NEURONS-1:0] sel_q,     sel_d;
  logic [CLOG2_TIMEOUT-1:0]     wdog_q,    wdog_d;
  logic [NUM_NEURONS*N-1:0]     results_q, results_d;
  logic                         error_q,   error_d;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    wdog_d    = wdog_q;
    results_d = results_q;
    error_d   = error_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_CLEAR;
          sel_d   = '0;
          error_d = 1'b0;
        end
      end

      ST_CLEAR: begin
        wdog_d  = '0;
        state_d = ST_RUN;
      end

      // A ready on the final watchdog cycle still counts as success.
      ST_RUN: begin
        wdog_d = wdog_q + 1'b1;
        if (bus.neuron_ready) begin
          state_d = ST_CAPTURE;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ST_ERR;
          error_d = 1'b1;
        end
      end

      ST_CAPTURE: begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (sel_q == CLOG2_NUM_NEURONS'(i)) begin
            results_d[i*N +: N] = bus.neuron_result;
          end
        end
        if (sel_q == SEL_LAST) begin
          state_d = ST_DONE;
        end else begin
          sel_d   = sel_q + 1'b1;
          state_d = ST_CLEAR;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      wdog_q    <= '0;
      results_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      wdog_q    <= wdog_d;
      results_q <= results_d;
      error_q   <= error_d;
    end
  end

  // Every output comes from a flop or a pure state decode.
  assign bus.neuron_rst = (state_q == ST_CLEAR);
  assign bus.neuron_en  = (state_q == ST_RUN);
  assign bus.busy       = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                          (state_q == ST_CAPTURE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.neuron_sel = sel_q;
  assign bus.results    = results_q;
  assign bus.error      = error_q;

endmodule
